// File: rtl/uart_baud_generator_if.sv
// ---------------------------------------------------------------------------
// uart_baud_generator_if
// Bundles the divider configuration coming from the UART register block and
// the timing ticks going to the TX/RX shift engines.
//
// Signals:
//   en           run enable (low clears the divider counters)
//   cfg_valid    single-cycle strobe loading cfg_int/cfg_frac and restarting
//   cfg_int      integer divisor minus one (N)
//   cfg_frac     fractional numerator F, over 2^FRAC_WIDTH
//   sample_tick  oversampling tick, one-cycle pulse
//   bit_tick     one-cycle pulse at each bit boundary
//   sck          50 % duty baud clock
//   rising_edge  first cycle sck is 1
//   falling_edge first cycle sck is 0 after being 1
//
// Modports:
//   master  register block / consumer side (drives config, reads ticks)
//   slave   the baud generator itself
// ---------------------------------------------------------------------------
interface uart_baud_generator_if #(
    parameter int unsigned DIV_WIDTH  = 16,
    parameter int unsigned FRAC_WIDTH = 4
);
    logic                  en;
    logic                  cfg_valid;
    logic [DIV_WIDTH-1:0]  cfg_int;
    logic [FRAC_WIDTH-1:0] cfg_frac;
    logic                  sample_tick;
    logic                  bit_tick;
    logic                  sck;
    logic                  rising_edge;
    logic                  falling_edge;

    modport master (
        output en, cfg_valid, cfg_int, cfg_frac,
        input  sample_tick, bit_tick, sck, rising_edge, falling_edge
    );

    modport slave (
        input  en, cfg_valid, cfg_int, cfg_frac,
        output sample_tick, bit_tick, sck, rising_edge, falling_edge
    );
endinterface

// File: rtl/uart_baud_generator.sv
// ---------------------------------------------------------------------------
// uart_baud_generator
// Fractional baud-rate divider. A counter runs to N (+1 when the fractional
// accumulator carried in the previous period) and emits a one-cycle
// sample_tick; every OVERSAMPLE sample ticks form one bit, giving bit_tick,
// a 50 % duty baud clock sck, and registered sck edge pulses.
// Average sample period = N + 1 + F/2^FRAC_WIDTH clock cycles.
//
// Ports:
//   clk  system clock
//   rst  asynchronous reset, active high
//   bus  uart_baud_generator_if.slave: en, cfg_valid, cfg_int, cfg_frac in;
//        sample_tick, bit_tick, sck, rising_edge, falling_edge out
// ---------------------------------------------------------------------------
module uart_baud_generator #(
    parameter int unsigned DIV_WIDTH  = 16,
    parameter int unsigned FRAC_WIDTH = 4,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_baud_generator_if.slave  bus
);

    localparam int unsigned PH_W  = $clog2(OVERSAMPLE);
    localparam int unsigned CNT_W = DIV_WIDTH + 1;

    if (DIV_WIDTH < 2 || FRAC_WIDTH < 1 || OVERSAMPLE < 2 ||
        (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_param_check
        $error("uart_baud_generator: illegal parameter set");
    end

    logic [DIV_WIDTH-1:0]  r_div_q,       w_div_nxt;
    logic [FRAC_WIDTH-1:0] r_frac_q,      w_frac_nxt;
    logic [CNT_W-1:0]      r_counter,     w_counter_nxt;
    logic [FRAC_WIDTH-1:0] r_acc,         w_acc_nxt;
    logic                  r_carry_q,     w_carry_nxt;
    logic [PH_W-1:0]       r_phase,       w_phase_nxt;
    logic                  r_sample_tick, w_sample_tick_nxt;
    logic                  r_bit_tick,    w_bit_tick_nxt;
    logic                  r_sck,         w_sck_nxt;
    logic                  r_rising,      w_rising_nxt;
    logic                  r_falling,     w_falling_nxt;

    logic [CNT_W-1:0]      w_target;
    logic [FRAC_WIDTH:0]   w_frac_sum;

    // One extra bit so N = max plus a carry does not wrap the target.
    assign w_target   = {1'b0, r_div_q} + CNT_W'(r_carry_q);
    assign w_frac_sum = {1'b0, r_acc} + {1'b0, r_frac_q};

    always_comb begin
        w_div_nxt         = r_div_q;
        w_frac_nxt        = r_frac_q;
        w_counter_nxt     = r_counter;
        w_acc_nxt         = r_acc;
        w_carry_nxt       = r_carry_q;
        w_phase_nxt       = r_phase;
        w_sck_nxt         = r_sck;
        w_sample_tick_nxt = 1'b0;
        w_bit_tick_nxt    = 1'b0;
        w_rising_nxt      = 1'b0;
        w_falling_nxt     = 1'b0;

        if (bus.cfg_valid) begin
            w_div_nxt     = bus.cfg_int;
            w_frac_nxt    = bus.cfg_frac;
            w_counter_nxt = '0;
            w_acc_nxt     = '0;
            w_carry_nxt   = 1'b0;
            w_phase_nxt   = '0;
            w_sck_nxt     = 1'b0;
        end else if (!bus.en) begin
            w_counter_nxt = '0;
            w_acc_nxt     = '0;
            w_carry_nxt   = 1'b0;
            w_phase_nxt   = '0;
            w_sck_nxt     = 1'b0;
        end else if (r_counter != w_target) begin
            w_counter_nxt = r_counter + 1'b1;
        end else begin
            w_counter_nxt     = '0;
            w_sample_tick_nxt = 1'b1;
            // Carry stretches the next period by one cycle.
            w_acc_nxt         = w_frac_sum[FRAC_WIDTH-1:0];
            w_carry_nxt       = w_frac_sum[FRAC_WIDTH];
            w_phase_nxt       = r_phase + 1'b1;
            // Upper half of the phase range is the high half of sck.
            w_sck_nxt         = w_phase_nxt[PH_W-1];
            w_rising_nxt      = w_sck_nxt & ~r_sck;
            w_falling_nxt     = ~w_sck_nxt & r_sck;
            w_bit_tick_nxt    = (w_phase_nxt == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_q       <= '0;
            r_frac_q      <= '0;
            r_counter     <= '0;
            r_acc         <= '0;
            r_carry_q     <= 1'b0;
            r_phase       <= '0;
            r_sample_tick <= 1'b0;
            r_bit_tick    <= 1'b0;
            r_sck         <= 1'b0;
            r_rising      <= 1'b0;
            r_falling     <= 1'b0;
        end else begin
            r_div_q       <= w_div_nxt;
            r_frac_q      <= w_frac_nxt;
            r_counter     <= w_counter_nxt;
            r_acc         <= w_acc_nxt;
            r_carry_q     <= w_carry_nxt;
            r_phase       <= w_phase_nxt;
            r_sample_tick <= w_sample_tick_nxt;
            r_bit_tick    <= w_bit_tick_nxt;
            r_sck         <= w_sck_nxt;
            r_rising      <= w_rising_nxt;
            r_falling     <= w_falling_nxt;
        end
    end

    assign bus.sample_tick  = r_sample_tick;
    assign bus.bit_tick     = r_bit_tick;
    assign bus.sck          = r_sck;
    assign bus.rising_edge  = r_rising;
    assign bus.falling_edge = r_falling;

endmodule

// File: tb/tb_uart_baud_generator.sv
// ---------------------------------------------------------------------------
// tb_uart_baud_generator
// Scoreboard bench for uart_baud_generator. The reference model predicts the
// k-th sample tick after a restart at en-high edge
//     T(k) = k*(N+1) + floor((k-1)*F / 2^FW)
// and derives sck / edges / bit_tick from k mod OVERSAMPLE. Expected ticks are
// queued by the stimulus; a monitor pops one per observed sample_tick.
// ---------------------------------------------------------------------------
module tb_uart_baud_generator;

    localparam int unsigned DW = 10;
    localparam int unsigned FW = 4;
    localparam int unsigned OS = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_baud_generator_if #(.DIV_WIDTH(DW), .FRAC_WIDTH(FW)) bus_if ();

    uart_baud_generator #(
        .DIV_WIDTH (DW),
        .FRAC_WIDTH(FW),
        .OVERSAMPLE(OS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    typedef struct {
        int unsigned edge_no;
        logic        sck;
        logic        rise;
        logic        fall;
        logic        bt;
    } tick_t;

    tick_t       sb[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned edge_cnt = 0;

    // Reference model state
    int unsigned m_n = 0;
    int unsigned m_f = 0;
    longint      m_j = 0;
    int unsigned m_k = 0;
    logic        m_sck = 1'b0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint t_of(input int unsigned k, input int unsigned n, input int unsigned f);
        return longint'(k) * (longint'(n) + 1) + ((longint'(k - 1) * longint'(f)) >> FW);
    endfunction

    function automatic void model_restart();
        m_j   = 0;
        m_k   = 0;
        m_sck = 1'b0;
    endfunction

    // Drive one cycle of inputs, predict the coming edge, return at posedge+1.
    task automatic step(input logic en, input logic cv, input int unsigned n, input int unsigned f);
        tick_t       rec;
        int unsigned ph;
        @(negedge clk);
        #1;
        bus_if.en        = en;
        bus_if.cfg_valid = cv;
        bus_if.cfg_int   = DW'(n);
        bus_if.cfg_frac  = FW'(f);
        if (cv) begin
            m_n = n;
            m_f = f;
            model_restart();
        end else if (!en) begin
            model_restart();
        end else begin
            m_j++;
            if (m_j == t_of(m_k + 1, m_n, m_f)) begin
                m_k++;
                ph          = m_k % OS;
                rec.edge_no = edge_cnt + 1;
                rec.sck     = (ph >= OS / 2);
                rec.rise    = (ph == OS / 2);
                rec.fall    = (ph == 0);
                rec.bt      = (ph == 0);
                m_sck       = rec.sck;
                sb.push_back(rec);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every presented sample_tick against the queue head.
    always @(negedge clk) begin
        tick_t r;
        if (rst) begin
            check("reset_outputs",
                  {bus_if.sample_tick, bus_if.bit_tick, bus_if.sck, bus_if.rising_edge, bus_if.falling_edge},
                  0);
        end else if (bus_if.sample_tick) begin
            if (sb.size() == 0) begin
                check("unexpected_tick", edge_cnt, 0);
            end else begin
                r = sb.pop_front();
                check("tick_edge", edge_cnt, r.edge_no);
                check("tick_sck", bus_if.sck, r.sck);
                check("tick_rise", bus_if.rising_edge, r.rise);
                check("tick_fall", bus_if.falling_edge, r.fall);
                check("tick_bit", bus_if.bit_tick, r.bt);
            end
        end else begin
            check("idle_pulses", {bus_if.bit_tick, bus_if.rising_edge, bus_if.falling_edge}, 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned guard;
        bus_if.en        = 1'b0;
        bus_if.cfg_valid = 1'b0;
        bus_if.cfg_int   = '0;
        bus_if.cfg_frac  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_sample_tick", bus_if.sample_tick, 0);
        check("rst_sck", bus_if.sck, 0);
        check("rst_bit_tick", bus_if.bit_tick, 0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // N=F=0 after reset: a tick every cycle
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 0, 0);

        // N=3, F=0
        step(1'b0, 1'b1, 3, 0);
        for (int i = 0; i < 140; i++) step(1'b1, 1'b0, 3, 0);

        // N=3, F=8: periods 4,4,5,4,5,...
        step(1'b1, 1'b1, 3, 8);
        for (int i = 0; i < 160; i++) step(1'b1, 1'b0, 3, 8);

        // en drop mid-bit at phase 11
        step(1'b0, 1'b1, 1, 0);
        guard = 0;
        while (m_k < 11 && guard < 1000) begin
            step(1'b1, 1'b0, 1, 0);
            guard++;
        end
        check("reach_phase11", m_k, 11);
        check("pre_drop_sck", bus_if.sck, 1);
        step(1'b0, 1'b0, 1, 0);
        check("drop_sck", bus_if.sck, 0);
        check("drop_fall", bus_if.falling_edge, 0);
        check("drop_bit", bus_if.bit_tick, 0);
        for (int i = 0; i < 60; i++) step(1'b1, 1'b0, 1, 0);

        // cfg_valid coinciding with a pending tick
        step(1'b1, 1'b1, 3, 0);
        guard = 0;
        while ((m_k == 0 || m_j + 1 != t_of(m_k + 1, m_n, m_f)) && guard < 1000) begin
            step(1'b1, 1'b0, 3, 0);
            guard++;
        end
        check("pending_tick_found", (guard < 1000), 1);
        step(1'b1, 1'b1, 5, 2);
        check("cfg_kills_tick", bus_if.sample_tick, 0);
        for (int i = 0; i < 120; i++) step(1'b1, 1'b0, 5, 2);

        // Asynchronous reset while sck is high
        guard = 0;
        while (m_sck != 1'b1 && guard < 1000) begin
            step(1'b1, 1'b0, 5, 2);
            guard++;
        end
        check("pre_rst_sck", bus_if.sck, 1);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_sck", bus_if.sck, 0);
        check("async_rst_tick", bus_if.sample_tick, 0);
        sb.delete();
        m_n = 0;
        m_f = 0;
        model_restart();
        @(negedge clk);
        #1;
        bus_if.en        = 1'b0;
        bus_if.cfg_valid = 1'b0;
        rst              = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 0, 0);

        // Maximum divisor and fraction: target must not wrap
        step(1'b1, 1'b1, (1 << DW) - 1, (1 << FW) - 1);
        for (int i = 0; i < 5200; i++) step(1'b1, 1'b0, 0, 0);
        check("max_div_ticks", m_k, 5);

        // Randomised traffic
        step(1'b1, 1'b1, $urandom_range(0, 7), $urandom_range(0, 15));
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 97) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                 $urandom_range(0, 7), $urandom_range(0, 15));
        end

        step(1'b0, 1'b0, 0, 0);
        @(negedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
